// File: rtl/am_pkg.sv
// Shared constants, marker encodings and BIP helpers for 40GBASE-R lane alignment markers.
// Used by the RX marker lock and reusable by the TX marker inserter.
package am_pkg;

   localparam int HEAD_W     = 2;
   localparam int DATA_W     = 64;
   localparam int BLOCK_W    = HEAD_W + DATA_W;
   localparam int NUM_LANES  = 4;
   localparam int LANE_W     = $clog2(NUM_LANES);
   localparam int BIP_W      = 8;
   localparam int ENC_W      = 24;
   localparam int CNT_W      = 14;
   localparam int AM_GAP_DEF = 16383;

   localparam logic [HEAD_W-1:0] SYNC_HEAD_CTRL = 2'b10;

   // {M2,M1,M0} per lane; M4..M6 are the bitwise inverse of these bytes.
   localparam logic [NUM_LANES-1:0][ENC_W-1:0] AM_ENC = {
      24'h3D79A2,
      24'h9B65C5,
      24'hE6C4F0,
      24'h477690
   };

   typedef enum logic [2:0] {
      ST_INIT,
      ST_FIND_1ST,
      ST_COUNT,
      ST_COMP_2ND,
      ST_LOCKED
   } am_state_e;

   function automatic logic am_match(input logic [BLOCK_W-1:0] blk,
                                     input logic [ENC_W-1:0]   enc);
      return (blk[1:0] == SYNC_HEAD_CTRL) && (blk[25:2] == enc) && (blk[57:34] == ~enc);
   endfunction

   // Each payload byte lane folds onto the same BIP bit; the two header bits land on bits 3 and 4.
   function automatic logic [BIP_W-1:0] bip_of(input logic [BLOCK_W-1:0] blk);
      return blk[9:2]   ^ blk[17:10] ^ blk[25:18] ^ blk[33:26] ^
             blk[41:34] ^ blk[49:42] ^ blk[57:50] ^ blk[65:58] ^
             {3'b000, blk[1:0], 3'b000};
   endfunction

endpackage

// File: rtl/am_lock_lane_rx_if.sv
// Block stream bundle: one 66-bit block plus its qualifier.
interface am_lock_lane_rx_if;
   import am_pkg::*;

   logic               valid;
   logic [BLOCK_W-1:0] data;

   modport master (output valid, output data);
   modport slave  (input  valid, input  data);

endinterface

// File: rtl/am_bip_acc.sv
// Interleaved BIP-8 accumulator over full 66-bit blocks with clear, load and accumulate.
module am_bip_acc
   import am_pkg::*;
(
   input  logic               clk,
   input  logic               nreset,
   input  logic               clear_i,
   input  logic               load_i,
   input  logic               acc_i,
   input  logic [BLOCK_W-1:0] block_i,
   output logic [BIP_W-1:0]   bip_o
);

   logic [BIP_W-1:0] acc_q, acc_d;

   // Load starts a new window with this block's own contribution.
   always_comb begin
      acc_d = acc_q;
      if (clear_i) begin
         acc_d = '0;
      end else if (load_i) begin
         acc_d = bip_of(block_i);
      end else if (acc_i) begin
         acc_d = acc_q ^ bip_of(block_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign bip_o = acc_q;

endmodule

// File: rtl/am_lock_lane_rx.sv
// Alignment marker lock for one 40GBASE-R receive lane: finds the lane marker,
// checks BIP3/BIP7 while locked and strips marker blocks from the data stream.
module am_lock_lane_rx
   import am_pkg::*;
#(
   parameter int AM_GAP    = AM_GAP_DEF,
   parameter int INVLD_MAX = 4
) (
   input  logic               clk,
   input  logic               nreset,
   input  logic               block_lock,
   am_lock_lane_rx_if.slave   rx_i,
   am_lock_lane_rx_if.master  tx_o,
   output logic               am_lock,
   output logic [LANE_W-1:0]  lane_o,
   output logic               bip_err,
   output logic [15:0]        bip_err_cnt
);

   localparam int INVLD_W = $clog2(INVLD_MAX + 1);
   localparam logic [CNT_W-1:0]   GAP   = CNT_W'(AM_GAP);
   localparam logic [INVLD_W-1:0] INVLD = INVLD_W'(INVLD_MAX);

   logic               valid_i;
   logic [BLOCK_W-1:0] data_i;

   am_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [INVLD_W-1:0] invld_q, invld_d, invld_inc;
   logic               lock_q, lock_d;
   logic [LANE_W-1:0]  rec_lane_q, rec_lane_d;
   logic [LANE_W-1:0]  lane_q, lane_d;
   logic               valid_o_q, valid_o_d;
   logic [BLOCK_W-1:0] data_o_q, data_o_d;
   logic               bip_err_q, bip_err_d;
   logic [15:0]        bip_cnt_q, bip_cnt_d;

   logic               hit, rec_match, slot, bip_load, bip_chk;
   logic [LANE_W-1:0]  hit_lane;
   logic [BIP_W-1:0]   bip_acc, bip3, bip7;

   assign valid_i = rx_i.valid;
   assign data_i  = rx_i.data;
   assign bip3    = data_i[33:26];
   assign bip7    = data_i[65:58];

   always_comb begin
      hit      = 1'b0;
      hit_lane = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (am_match(data_i, AM_ENC[l[LANE_W-1:0]])) begin
            hit      = 1'b1;
            hit_lane = l[LANE_W-1:0];
         end
      end
      rec_match = am_match(data_i, AM_ENC[rec_lane_q]);
   end

   am_bip_acc u_bip_acc (
      .clk     (clk),
      .nreset  (nreset),
      .clear_i (!block_lock || (state_q == ST_INIT)),
      .load_i  (bip_load),
      .acc_i   (valid_i),
      .block_i (data_i),
      .bip_o   (bip_acc)
   );

   // Lock FSM; only valid blocks advance it, except losing block lock which acts at once.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      invld_d    = invld_q;
      lock_d     = lock_q;
      rec_lane_d = rec_lane_q;
      lane_d     = lane_q;
      slot       = 1'b0;
      bip_load   = 1'b0;
      bip_chk    = 1'b0;
      invld_inc  = invld_q + 1'b1;

      if (!block_lock) begin
         state_d = ST_INIT;
         cnt_d   = '0;
         invld_d = '0;
         lock_d  = 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               cnt_d   = '0;
               invld_d = '0;
               lock_d  = 1'b0;
               state_d = ST_FIND_1ST;
            end
            ST_FIND_1ST: begin
               if (valid_i && hit) begin
                  rec_lane_d = hit_lane;
                  cnt_d      = '0;
                  bip_load   = 1'b1;
                  state_d    = ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (valid_i) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_d == GAP) begin
                     state_d = ST_COMP_2ND;
                  end
               end
            end
            ST_COMP_2ND: begin
               if (valid_i) begin
                  bip_load = 1'b1;
                  cnt_d    = '0;
                  if (rec_match) begin
                     lock_d  = 1'b1;
                     lane_d  = rec_lane_q;
                     state_d = ST_LOCKED;
                  end else begin
                     state_d = ST_FIND_1ST;
                  end
               end
            end
            ST_LOCKED: begin
               if (valid_i) begin
                  if (cnt_q == GAP) begin
                     slot     = 1'b1;
                     bip_load = 1'b1;
                     cnt_d    = '0;
                     if (rec_match) begin
                        invld_d = '0;
                        bip_chk = 1'b1;
                     end else if (invld_inc == INVLD) begin
                        invld_d = '0;
                        lock_d  = 1'b0;
                        state_d = ST_FIND_1ST;
                     end else begin
                        invld_d = invld_inc;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = ST_INIT;
         endcase
      end

      valid_o_d = valid_i & block_lock & lock_q & ~slot;
      data_o_d  = valid_i ? data_i : data_o_q;
      bip_err_d = bip_chk & ((bip3 != bip_acc) | (bip7 != ~bip3));
      bip_cnt_d = (bip_err_d && (bip_cnt_q != 16'hFFFF)) ? bip_cnt_q + 1'b1 : bip_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         invld_q    <= '0;
         lock_q     <= 1'b0;
         rec_lane_q <= '0;
         lane_q     <= '0;
         valid_o_q  <= 1'b0;
         data_o_q   <= '0;
         bip_err_q  <= 1'b0;
         bip_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         invld_q    <= invld_d;
         lock_q     <= lock_d;
         rec_lane_q <= rec_lane_d;
         lane_q     <= lane_d;
         valid_o_q  <= valid_o_d;
         data_o_q   <= data_o_d;
         bip_err_q  <= bip_err_d;
         bip_cnt_q  <= bip_cnt_d;
      end
   end

   assign tx_o.valid  = valid_o_q;
   assign tx_o.data   = data_o_q;
   assign am_lock     = lock_q;
   assign lane_o      = lane_q;
   assign bip_err     = bip_err_q;
   assign bip_err_cnt = bip_cnt_q;

endmodule

// File: tb/tb_am_lock_lane_rx.sv
// Directed bench for am_lock_lane_rx with a 16-block marker period (AM_GAP=15).
module tb_am_lock_lane_rx;

   logic        clk = 1'b0;
   logic        nreset;
   logic        blockLock;
   logic        amLock;
   logic [1:0]  laneOut;
   logic        bipErr;
   logic [15:0] bipErrCnt;

   int          checks = 0;
   int          errors = 0;
   int          seqNo  = 0;
   logic [7:0]  accModel;
   logic        expLock;
   logic [1:0]  expLane;
   logic [15:0] expCnt;

   am_lock_lane_rx_if rxIf ();
   am_lock_lane_rx_if txIf ();

   am_lock_lane_rx #(
      .AM_GAP    (15),
      .INVLD_MAX (4)
   ) dut (
      .clk         (clk),
      .nreset      (nreset),
      .block_lock  (blockLock),
      .rx_i        (rxIf),
      .tx_o        (txIf),
      .am_lock     (amLock),
      .lane_o      (laneOut),
      .bip_err     (bipErr),
      .bip_err_cnt (bipErrCnt)
   );

   always #5 clk = ~clk;

   // BIP bit k collects data bits k+2, k+10, ..., k+58; header bits add onto bits 3 and 4.
   function automatic logic [7:0] bipModel(input logic [65:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int k = 0; k < 8; k++) begin
         for (int m = 0; m < 8; m++) begin
            r[3'(k)] = r[3'(k)] ^ b[7'(k + 2 + 8 * m)];
         end
      end
      r[3] = r[3] ^ b[0];
      r[4] = r[4] ^ b[1];
      return r;
   endfunction

   function automatic logic [65:0] makeMarker(input int lane, input logic [7:0] bip3,
                                              input logic [7:0] bip7);
      logic [23:0] m;
      case (lane)
         0:       m = {8'h47, 8'h76, 8'h90};
         1:       m = {8'hE6, 8'hC4, 8'hF0};
         2:       m = {8'h9B, 8'h65, 8'hC5};
         default: m = {8'h3D, 8'h79, 8'hA2};
      endcase
      return {bip7, ~m, bip3, m, 2'b10};
   endfunction

   function automatic logic [65:0] makeData(input int n);
      return {32'(n) ^ 32'h13579BDF, 32'(n) * 32'h9E3779B1, 2'b01};
   endfunction

   task automatic checkOutput(input string tag, input logic [65:0] observed,
                              input logic [65:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [65:0] blk,
                                input logic expValid, input logic expBip);
      rxIf.valid = v;
      rxIf.data  = blk;
      @(posedge clk);
      #1;
      checkOutput("valid_o", 66'(txIf.valid), 66'(expValid));
      if (expValid) checkOutput("data_o", txIf.data, blk);
      checkOutput("am_lock", 66'(amLock), 66'(expLock));
      checkOutput("lane_o", 66'(laneOut), 66'(expLane));
      checkOutput("bip_err", 66'(bipErr), 66'(expBip));
      checkOutput("bip_err_cnt", 66'(bipErrCnt), 66'(expCnt));
   endtask

   task automatic sendData(input int count, input logic expValid, input int flipAt,
                           input logic gapped);
      logic [65:0] blk;
      for (int i = 0; i < count; i++) begin
         seqNo++;
         blk = makeData(seqNo);
         accModel = accModel ^ bipModel(blk);
         if (i == flipAt) blk[10] = ~blk[10];
         applyStimulus(1'b1, blk, expValid, 1'b0);
         if (gapped) applyStimulus(1'b0, makeMarker(2, 8'h00, 8'hFF), 1'b0, 1'b0);
      end
   endtask

   task automatic sendMarker(input int lane, input logic [7:0] bip3, input logic [7:0] bip7,
                             input logic expBip);
      logic [65:0] blk;
      blk = makeMarker(lane, bip3, bip7);
      applyStimulus(1'b1, blk, 1'b0, expBip);
      accModel = bipModel(blk);
   endtask

   task automatic sendGood(input int lane);
      sendMarker(lane, accModel, ~accModel, 1'b0);
   endtask

   task automatic sendBad(input int kind);
      logic [65:0] blk;
      case (kind)
         0:       blk = makeData(1000 + seqNo);
         1:       blk = makeMarker(0, accModel, ~accModel);
         default: begin
            blk = makeMarker(2, accModel, ~accModel);
            blk[12] = ~blk[12];
         end
      endcase
      applyStimulus(1'b1, blk, 1'b0, 1'b0);
      accModel = bipModel(blk);
   endtask

   initial begin
      nreset     = 1'b0;
      blockLock  = 1'b1;
      rxIf.valid = 1'b0;
      rxIf.data  = '0;
      accModel   = 8'h00;
      expLock    = 1'b0;
      expLane    = 2'd0;
      expCnt     = 16'd0;

      @(posedge clk);
      applyStimulus(1'b0, 66'd0, 1'b0, 1'b0);
      checkOutput("data_o_reset", txIf.data, 66'd0);
      nreset = 1'b1;
      applyStimulus(1'b0, 66'd0, 1'b0, 1'b0);

      $display("[TB] lane2 acquisition");
      sendMarker(2, 8'h00, 8'hFF, 1'b0);
      sendData(15, 1'b0, -1, 1'b0);
      expLock = 1'b1;
      expLane = 2'd2;
      sendGood(2);
      sendData(15, 1'b1, -1, 1'b0);
      sendGood(2);

      $display("[TB] BIP errors");
      sendData(15, 1'b1, 7, 1'b0);
      expCnt = 16'd1;
      sendMarker(2, accModel, ~accModel, 1'b1);
      sendData(15, 1'b1, -1, 1'b0);
      expCnt = 16'd2;
      sendMarker(2, accModel, accModel, 1'b1);
      for (int p = 0; p < 3; p++) begin
         sendData(15, 1'b1, -1, 1'b0);
         expCnt = expCnt + 16'd1;
         sendMarker(2, accModel ^ 8'h80, ~(accModel ^ 8'h80), 1'b1);
      end

      $display("[TB] gapped valid");
      sendData(15, 1'b1, -1, 1'b1);
      sendGood(2);

      $display("[TB] invalid markers");
      for (int p = 0; p < 3; p++) begin
         sendData(15, 1'b1, -1, 1'b0);
         sendBad(p);
      end
      sendData(15, 1'b1, -1, 1'b0);
      sendGood(2);
      for (int p = 0; p < 4; p++) begin
         sendData(15, 1'b1, -1, 1'b0);
         if (p == 3) expLock = 1'b0;
         sendBad(p % 3);
      end
      sendData(3, 1'b0, -1, 1'b0);

      $display("[TB] lane1 failed then good acquisition");
      sendMarker(1, 8'h00, 8'hFF, 1'b0);
      sendData(15, 1'b0, -1, 1'b0);
      sendBad(0);
      sendMarker(1, 8'h00, 8'hFF, 1'b0);
      sendData(15, 1'b0, -1, 1'b0);
      expLock = 1'b1;
      expLane = 2'd1;
      sendGood(1);
      sendData(5, 1'b1, -1, 1'b0);

      $display("[TB] block_lock drop and reset");
      blockLock = 1'b0;
      expLock   = 1'b0;
      sendData(2, 1'b0, -1, 1'b0);
      nreset  = 1'b0;
      expLane = 2'd0;
      expCnt  = 16'd0;
      applyStimulus(1'b0, 66'd0, 1'b0, 1'b0);
      checkOutput("data_o_reset", txIf.data, 66'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/am_lock_lane_rx.md
# am_lock_lane_rx

Receive-side alignment marker lock for one 40GBASE-R PCS lane. It sits after the per-lane block synchroniser and before lane deskew/reorder. It searches for any of the four lane alignment markers, locks when two markers arrive exactly one marker period apart, and reports the physical-to-logical lane number. While locked it checks BIP3/BIP7, removes marker blocks from the stream and drops lock after repeated marker mismatches.

## Interface
- HEAD_W, 2, sync header width
- DATA_W, 64, block payload width
- BLOCK_W, HEAD_W+DATA_W, full block width
- NUM_LANES, 4, number of candidate marker encodings
- AM_GAP, 16383, data blocks between consecutive markers; reduced in simulation only
- INVLD_MAX, 4, consecutive bad markers that drop lock
- clk  in  1  clock
- nreset  in  1  synchronous, active-low reset
- block_lock  in  1  block lock from the synchroniser; low forces INIT
- valid_i  in  1  data_i carries a block this cycle
- data_i  in  BLOCK_W  received block, header in [1:0]
- valid_o  out  1  data_o is a data block; low for markers and when unlocked
- data_o  out  BLOCK_W  registered copy of data_i
- am_lock  out  1  lane marker lock
- lane_o  out  2  logical lane number of the locked marker
- bip_err  out  1  one-cycle pulse on a BIP mismatch
- bip_err_cnt  out  16  saturating BIP error count, cleared only by reset

## Operation
- Marker match: data_i[1:0]==2'b10, and payload bytes M0,M1,M2,M4,M5,M6 (payload bits [23:0] and [55:32], i.e. data_i[25:2] and data_i[57:34]) equal the lane encoding. BIP bytes are excluded from the match.
- Lane encodings (M0,M1,M2), with M4..M6 their bitwise inverses:
  - lane0 90,76,47
  - lane1 F0,C4,E6
  - lane2 C5,65,9B
  - lane3 A2,79,3D
- A match against any lane is a "hit" and yields lane index L. A match against the recorded lane is a "valid marker".
- States, evaluated only on cycles with valid_i=1:
  - INIT: entered on reset or block_lock=0 from any state. Clears counter, invld_cnt and am_lock. Moves to FIND_1ST when block_lock=1.
  - FIND_1ST: a hit records L and clears the counter, then goes to COUNT.
  - COUNT: counter increments per valid block. When the counter reaches AM_GAP, go to COMP_2ND; the next valid block is the marker slot.
  - COMP_2ND: valid marker sets am_lock=1 and lane_o=L, goes to LOCKED. Anything else returns to FIND_1ST; that block is not itself re-searched.
  - LOCKED: counts AM_GAP data blocks, then evaluates the marker slot.
    - Valid marker clears invld_cnt.
    - Otherwise invld_cnt increments. At INVLD_MAX, go to FIND_1ST and clear am_lock.
- Marker slot output: valid_o=0 whenever state is LOCKED at the slot, regardless of match. The slot is never forwarded as data.
- Data output: valid_o = valid_i & am_lock & not marker slot.
- BIP accumulator (8 bits) uses the 802.3 Clause 82 lane-interleave map over all 66 bits:
  - bit k, k=0..7, takes data_i bits k+2, k+10, …, k+58
  - bit 3 additionally takes data_i[0]; bit 4 additionally takes data_i[1]
  - bit 5 takes data_i[7], 15, …, 63; bit 6 takes 8, …, 64; bit 7 takes 9, …, 65
- BIP window: accumulates every valid block from a marker (inclusive) up to the next marker slot (exclusive). At the slot, reload the accumulator with the slot block's contribution.
- BIP check, only in LOCKED on a valid marker:
  - error if received BIP3 (payload byte 3, data_i[33:26]) ≠ accumulator
  - error if BIP7 (data_i[65:58]) ≠ ~BIP3
  - either error pulses bip_err once and increments bip_err_cnt, saturating at FFFF
  - no check on the first lock marker (COMP_2ND)

## Timing
- All outputs are registered. data_o, valid_o and bip_err appear one cycle after the sampled input.
- am_lock and lane_o update one cycle after the deciding marker slot.
- Reset values: valid_o=0, data_o=0, am_lock=0, lane_o=0, bip_err=0, bip_err_cnt=0.
- valid_i=0 cycles freeze the counter, state and accumulator; outputs hold with valid_o=0.
- block_lock falling mid-period: next cycle am_lock=0, valid_o=0, state INIT. bip_err_cnt is retained.
- Counter is 14 bits; its wrap is never reached because it is compared to AM_GAP.

## Structure
- Package am_pkg: lane encoding array, SYNC_HEAD_CTRL=2'b10, AM_GAP default, BIP_W=8, state enum.
- Sub-module am_bip_acc: 66-bit interleaved XOR with clear/load and accumulate. It is reusable by the TX marker inserter.

## Test plan
- Lane2 markers every AM_GAP=15 data blocks (16-block period) -> am_lock=1 after the second marker, lane_o=2, marker blocks have valid_o=0, and the 15 data blocks between them pass.
- First lane1 hit, then a block at the expected slot that is not a marker -> no lock, return to FIND_1ST; next two good markers lock.
- Locked, flip one data bit (data_i[10]) in one period -> exactly one bip_err pulse, bip_err_cnt=1. Set BIP7 to something other than ~BIP3 with BIP3 correct -> bip_err_cnt=2.
- Locked, 3 corrupted markers then a good one -> lock held, invld_cnt cleared. Later, 4 consecutive corrupted markers -> am_lock=0 the cycle after the 4th slot.
- valid_i gapped 50% while locked -> counter tracks only valid blocks, lock held, no bip_err.
- block_lock dropped mid-period -> am_lock=0 next cycle. Assert nreset with bip_err_cnt=5 -> all outputs zero.
